// File: rtl/axi_dac_pkg.sv
// Shared definitions for the DAC AXI4-Lite register slave.
// Holds register byte offsets, CTRL bit positions, bus widths and the
// AXI response encoding used by the interface, top and pacer.
package axi_dac_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned REG_NUM  = 4;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] CHA_OFS    = 4'h4;
  localparam logic [3:0] CHB_OFS    = 4'h8;
  localparam logic [3:0] PERIOD_OFS = 4'hC;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_SYNC_BIT = 1;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Register index (word select) for a byte offset.
  function automatic logic [1:0] reg_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/axi_dac_regs_slave_if.sv
// AXI4-Lite bus bundle between a master and the DAC register slave.
// Carries the AW, W, B, AR and R channels; the slave modport is used by
// axi_dac_regs_slave, the master modport by whatever drives it.
interface axi_dac_regs_slave_if
  import axi_dac_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axi_dac_pacer.sv
// Sample-rate pacer for the DAC outputs.
// Ports: clk/rst (async active-high); en, period, ch_a, ch_b, sync in;
// dac_a, dac_b holding registers and one-cycle dac_update strobe out.
// Counter runs while en is high and reloads the outputs whenever it
// reaches period; a sync pulse forces a reload regardless of en.
module axi_dac_pacer
  import axi_dac_pkg::*;
#(
  parameter int unsigned DAC_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DAC_W-1:0]    ch_a,
  input  logic [DAC_W-1:0]    ch_b,
  input  logic                sync,
  output logic [DAC_W-1:0]    dac_a,
  output logic [DAC_W-1:0]    dac_b,
  output logic                dac_update
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DAC_W-1:0]    dac_a_q, dac_a_d;
  logic [DAC_W-1:0]    dac_b_q, dac_b_d;
  logic                upd_q, upd_d;
  logic                load_c;

  // Next-state: >= compare so a shrunken period never waits for a wrap;
  // sync and terminal count in the same cycle merge into one load.
  always_comb begin
    cnt_d   = cnt_q;
    dac_a_d = dac_a_q;
    dac_b_d = dac_b_q;
    upd_d   = 1'b0;
    load_c  = 1'b0;
    if (en) begin
      if (cnt_q >= period) begin
        cnt_d  = '0;
        load_c = 1'b1;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    if (sync) begin
      cnt_d  = '0;
      load_c = 1'b1;
    end
    if (load_c) begin
      dac_a_d = ch_a;
      dac_b_d = ch_b;
      upd_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dac_a_q <= '0;
      dac_b_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dac_a_q <= dac_a_d;
      dac_b_q <= dac_b_d;
      upd_q   <= upd_d;
    end
  end

  assign dac_a      = dac_a_q;
  assign dac_b      = dac_b_q;
  assign dac_update = upd_q;

endmodule

// File: rtl/axi_dac_regs_slave.sv
// AXI4-Lite register slave for the DAC block.
// Ports: ACLK, ARESET (async active-high); s_axi slave modport carrying
// the five AXI4-Lite channels; dac_a/dac_b codes and dac_update strobe.
// Registers: CTRL (EN, SYNC), CH_A, CH_B, PERIOD, selected by addr[3:2].
// Optional macro AXI_DAC_SLVERR_EN: nonzero address bits above [3:2]
// drop writes and zero reads with SLVERR; otherwise they alias.
module axi_dac_regs_slave
  import axi_dac_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_DAC_WIDTH        = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi_dac_regs_slave_if.slave    s_axi,
  output logic [C_DAC_WIDTH-1:0] dac_a,
  output logic [C_DAC_WIDTH-1:0] dac_b,
  output logic                   dac_update
);

  localparam int unsigned STRB_W     = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  CTRL_IDX   = reg_idx(CTRL_OFS);
  localparam logic [1:0]  CHA_IDX    = reg_idx(CHA_OFS);
  localparam logic [1:0]  CHB_IDX    = reg_idx(CHB_OFS);
  localparam logic [1:0]  PERIOD_IDX = reg_idx(PERIOD_OFS);

  logic              aw_valid_q, aw_valid_d;
  logic [1:0]        aw_idx_q, aw_idx_d;
  logic              aw_err_q, aw_err_d;
  logic              w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              b_valid_q, b_valid_d;
  resp_t             b_resp_q, b_resp_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  resp_t             r_resp_q, r_resp_d;
  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_c, ar_addr_c;
  logic aw_hs_c, w_hs_c, ar_hs_c;
  logic aw_err_c, ar_err_c;
  logic sync_c;
  logic unused_c;

  assign aw_addr_c = s_axi.S_AXI_AWADDR;
  assign ar_addr_c = s_axi.S_AXI_ARADDR;

`ifdef AXI_DAC_SLVERR_EN
  assign aw_err_c = (aw_addr_c >> 4) != '0;
  assign ar_err_c = (ar_addr_c >> 4) != '0;
`else
  assign aw_err_c = 1'b0;
  assign ar_err_c = 1'b0;
`endif

  // Protection bits and byte-offset bits carry no meaning here.
  assign unused_c = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_c, ar_addr_c};

  assign s_axi.S_AXI_AWREADY = !aw_valid_q && !b_valid_q;
  assign s_axi.S_AXI_WREADY  = !w_valid_q && !b_valid_q;
  assign s_axi.S_AXI_ARREADY = !r_valid_q;

  assign aw_hs_c = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs_c  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_hs_c = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  // Channel latching, register update and response generation.
  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_idx_d   = aw_idx_q;
    aw_err_d   = aw_err_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    regs_d     = regs_q;
    sync_c     = 1'b0;

    if (aw_hs_c) begin
      aw_valid_d = 1'b1;
      aw_idx_d   = aw_addr_c[3:2];
      aw_err_d   = aw_err_c;
    end
    if (w_hs_c) begin
      w_valid_d = 1'b1;
      w_data_d  = s_axi.S_AXI_WDATA;
      w_strb_d  = s_axi.S_AXI_WSTRB;
    end
    if (b_valid_q && s_axi.S_AXI_BREADY) begin
      b_valid_d = 1'b0;
    end

    // Both halves present: commit the write and raise the response.
    if (aw_valid_q && w_valid_q) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      b_valid_d  = 1'b1;
      if (aw_err_q) begin
        b_resp_d = SLVERR;
      end else begin
        b_resp_d = OKAY;
        for (int b = 0; b < int'(STRB_W); b++) begin
          if (w_strb_q[b]) begin
            regs_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        if (aw_idx_q == CTRL_IDX && w_strb_q[0] && w_data_q[CTRL_SYNC_BIT]) begin
          sync_c = 1'b1;
        end
      end
    end

    if (r_valid_q && s_axi.S_AXI_RREADY) begin
      r_valid_d = 1'b0;
    end
    // Reads sample the current registers, so a same-cycle write is not seen.
    if (ar_hs_c) begin
      r_valid_d = 1'b1;
      if (ar_err_c) begin
        r_data_d = '0;
        r_resp_d = SLVERR;
      end else begin
        r_data_d = regs_q[ar_addr_c[3:2]];
        r_resp_d = OKAY;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_valid_q <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_idx_q   <= aw_idx_d;
      aw_err_q   <= aw_err_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_axi.S_AXI_BVALID = b_valid_q;
  assign s_axi.S_AXI_BRESP  = b_resp_q;
  assign s_axi.S_AXI_RVALID = r_valid_q;
  assign s_axi.S_AXI_RDATA  = r_data_q;
  assign s_axi.S_AXI_RRESP  = r_resp_q;

  axi_dac_pacer #(
    .DAC_W(C_DAC_WIDTH)
  ) u_pacer (
    .clk       (ACLK),
    .rst       (ARESET),
    .en        (regs_q[CTRL_IDX][CTRL_EN_BIT]),
    .period    (regs_q[PERIOD_IDX][PERIOD_W-1:0]),
    .ch_a      (regs_q[CHA_IDX][C_DAC_WIDTH-1:0]),
    .ch_b      (regs_q[CHB_IDX][C_DAC_WIDTH-1:0]),
    .sync      (sync_c),
    .dac_a     (dac_a),
    .dac_b     (dac_b),
    .dac_update(dac_update)
  );

endmodule

// File: tb/tb_axi_dac_regs_slave.sv
// Self-checking bench for axi_dac_regs_slave: directed steps plus random
// register traffic, checked against a word-array register model and a
// strobe-interval model of the pacer.
module tb_axi_dac_regs_slave;
  import axi_dac_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_dac_regs_slave_if #(.ADDR_W(AW)) bus ();
  logic [DW-1:0] dac_a, dac_b;
  logic          dac_update;

  axi_dac_regs_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_DAC_WIDTH       (DW)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .s_axi     (bus),
    .dac_a     (dac_a),
    .dac_b     (dac_b),
    .dac_update(dac_update)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int b_rise_cyc = 0;
  int strobe_total = 0;
  int last_strobe_cyc = -1;
  logic [DW-1:0] last_a = '0, last_b = '0;
  int strobe_q[$];
  logic [31:0] m_regs [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dac_update === 1'b1) begin
      strobe_q.push_back(cyc);
      strobe_total    <= strobe_total + 1;
      last_a          <= dac_a;
      last_b          <= dac_b;
      last_strobe_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_err(input logic [AW-1:0] addr);
`ifdef AXI_DAC_SLVERR_EN
    return addr[AW-1:4] != '0;
`else
    return (addr == '1) && 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
    return addr_err(addr) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (!addr_err(addr)) m_regs[addr[3:2]] = merge(m_regs[addr[3:2]], data, strb);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int bhold);
    int n; int early; int hold_bad; bit aw_done, w_done, aw_fire, w_fire;
    n = 0; early = 0; hold_bad = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && n < 200) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID) early++;
      bus.S_AXI_AWVALID = !aw_done && (n >= aw_dly);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWPROT  = 3'($urandom);
      bus.S_AXI_WVALID  = !w_done && (n >= w_dly);
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      n++;
    end
    check("wr_handshake", 32'(aw_done && w_done), 32'd1);
    check("b_before_both", 32'(early), 32'd0);
    @(negedge clk);
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID  = 0;
    check("b_not_yet", 32'(bus.S_AXI_BVALID), 32'd0);
    @(posedge clk); @(negedge clk);
    check("b_latency", 32'(bus.S_AXI_BVALID), 32'd1);
    b_rise_cyc = cyc;
    for (int i = 0; i < bhold; i++) begin
      bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = addr;
      bus.S_AXI_WVALID  = 1; bus.S_AXI_WDATA = ~data; bus.S_AXI_WSTRB = 4'hF;
      if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY || bus.S_AXI_WREADY) hold_bad++;
      @(posedge clk); @(negedge clk);
    end
    if (bhold > 0) begin
      check("b_hold", 32'(hold_bad), 32'd0);
      bus.S_AXI_AWVALID = 0;
      bus.S_AXI_WVALID  = 0;
    end
    check($sformatf("bresp@%0h", addr), 32'(bus.S_AXI_BRESP), 32'(exp_resp(addr)));
    bus.S_AXI_BREADY = 1;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_BREADY = 0;
    check("b_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    model_write(addr, data, strb);
  endtask

  task automatic rd_check(input logic [AW-1:0] addr, input int rdly);
    int n; logic [31:0] d; logic [1:0] r;
    n = 0;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARPROT = 3'($urandom);
    while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    check("ar_ready", 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.S_AXI_ARVALID = 0;
    check("r_latency", 32'(bus.S_AXI_RVALID), 32'd1);
    repeat (rdly) begin @(posedge clk); @(negedge clk); end
    d = bus.S_AXI_RDATA; r = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_RREADY = 0;
    check("r_drop", 32'(bus.S_AXI_RVALID), 32'd0);
    check($sformatf("rdata@%0h", addr), d, addr_err(addr) ? 32'd0 : m_regs[addr[3:2]]);
    check($sformatf("rresp@%0h", addr), 32'(r), 32'(exp_resp(addr)));
  endtask

  task automatic pace_check(input int period, input int n);
    int bad;
    axi_write(5'h04, $urandom, 4'hF, 0, 0, 0);
    axi_write(5'h08, $urandom, 4'hF, 0, 0, 0);
    axi_write(5'h0C, {16'($urandom), 16'(period)}, 4'hF, 0, 0, 0);
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0);
    @(posedge clk);
    strobe_q.delete();
    repeat ((period + 1) * (n + 1) + 2) @(negedge clk);
    check($sformatf("pace_count_p%0d", period), 32'(strobe_q.size() >= n), 32'd1);
    bad = 0;
    for (int i = 1; i < strobe_q.size(); i++)
      if (strobe_q[i] - strobe_q[i-1] != period + 1) bad++;
    check($sformatf("pace_interval_p%0d", period), 32'(bad), 32'd0);
    check("pace_dac_a", 32'(last_a), m_regs[1] & 32'h0000FFFF);
    check("pace_dac_b", 32'(last_b), m_regs[2] & 32'h0000FFFF);
  endtask

  initial begin
    int base; int n; logic [31:0] old_v; logic [31:0] nv;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0;
    bus.S_AXI_WVALID = 0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_BREADY = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARPROT = '0; bus.S_AXI_RREADY = 0;
    #2 rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("rst_wready", 32'(bus.S_AXI_WREADY), 32'd1);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    check("rst_dac_a", 32'(dac_a), 32'd0);
    check("rst_update", 32'(dac_update), 32'd0);

    // Basic write/readback of all four registers
    for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd_check(AW'(4 * i), i % 2);

    // AW three cycles ahead of W, partial strobes
    axi_write(5'h04, 32'hDEADBEEF, 4'b0101, 0, 3, 0);
    rd_check(5'h04, 0);
    check("strobe_lanes", m_regs[1], 32'h00AD00EF);

    // Back-pressured B with a second write offered meanwhile
    axi_write(5'h08, 32'hCAFE0123, 4'hF, 2, 0, 10);
    rd_check(5'h08, 2);

    // Pacing, including a mid-count shrink of PERIOD
    pace_check(3, 4);
    check("pace_a_1234", 32'(last_a), m_regs[1] & 32'h0000FFFF);
    pace_check(0, 8);
    pace_check(40, 2);
    base = strobe_total; n = 0;
    while (strobe_total == base && n < 100) begin @(negedge clk); n++; end
    check("wait_strobe", 32'(n < 100), 32'd1);
    repeat (20) @(negedge clk);
    pace_check(2, 5);
    for (int k = 0; k < 3; k++) pace_check(int'($urandom_range(6, 0)), 4);

    // EN=0 stops the strobes
    axi_write(5'h00, 32'h0, 4'hF, 0, 0, 0);
    repeat (3) @(negedge clk);
    base = strobe_total;
    repeat (30) @(negedge clk);
    check("en0_no_strobe", 32'(strobe_total - base), 32'd0);

    // SYNC with EN=0: exactly one load on the cycle BVALID rises
    axi_write(5'h08, 32'h0000ABCD, 4'hF, 0, 0, 0);
    repeat (3) @(negedge clk);
    base = strobe_total;
    axi_write(5'h00, 32'h2, 4'hF, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("sync_one_strobe", 32'(strobe_total - base), 32'd1);
    check("sync_dac_b", 32'(last_b), 32'h0000ABCD);
    check("sync_timing", 32'(last_strobe_cyc), 32'(b_rise_cyc));
    base = strobe_total;
    repeat (20) @(negedge clk);
    check("sync_only_on_write", 32'(strobe_total - base), 32'd0);
    rd_check(5'h00, 0);

    // Read and write of the same register in the same cycle
    old_v = m_regs[2]; nv = $urandom;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 5'h08;
    bus.S_AXI_WVALID = 1; bus.S_AXI_WDATA = nv; bus.S_AXI_WSTRB = 4'hF;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = 5'h08;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_ARVALID = 0;
    check("coll_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("coll_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("coll_old_data", bus.S_AXI_RDATA, old_v);
    bus.S_AXI_RREADY = 1; bus.S_AXI_BREADY = 1;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_RREADY = 0; bus.S_AXI_BREADY = 0;
    model_write(5'h08, nv, 4'hF);
    rd_check(5'h08, 0);

    // Upper address bits: alias or SLVERR depending on build
    axi_write(5'h14, 32'h00000077, 4'hF, 0, 0, 0);
    rd_check(5'h04, 0);
    rd_check(5'h10, 0);
    rd_check(5'h1C, 1);

    // Random register traffic
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(1, 0) == 1)
        axi_write(AW'($urandom), $urandom, 4'($urandom), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
      else
        rd_check(AW'($urandom), int'($urandom_range(2, 0)));
    end

    // Reset with a write response pending
    axi_write(5'h04, 32'h00005555, 4'hF, 0, 0, 0);
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("pre_rst_dac_a", 32'(dac_a), 32'h00005555);
    bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 5'h08;
    bus.S_AXI_WVALID = 1; bus.S_AXI_WDATA = 32'h11112222; bus.S_AXI_WSTRB = 4'hF;
    @(posedge clk); @(negedge clk);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    rst = 1;
    #1;
    check("arst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("arst_dac_a", 32'(dac_a), 32'd0);
    check("arst_dac_b", 32'(dac_b), 32'd0);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) rd_check(AW'(4 * i), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
